// File: rtl/demod_ctrl.sv
// Sequencer between paired real/imag FWFT sample FIFOs, a demod core and an output FIFO.
// Optional macro DEMOD_CTRL_COUNT_EN enables the sample_count output counter.
module demod_ctrl #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] real_dout,
    input  logic                 real_empty,
    output logic                 real_rd_en,
    input  logic [DATA_SIZE-1:0] imag_dout,
    input  logic                 imag_empty,
    output logic                 imag_rd_en,
    output logic                 core_start,
    output logic [DATA_SIZE-1:0] core_cur_real,
    output logic [DATA_SIZE-1:0] core_cur_imag,
    output logic [DATA_SIZE-1:0] core_prev_real,
    output logic [DATA_SIZE-1:0] core_prev_imag,
    input  logic                 core_done,
    input  logic [DATA_SIZE-1:0] core_result,
    output logic [DATA_SIZE-1:0] out_din,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [31:0]          sample_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    state_t               state, state_nxt;
    logic                 pop, start, capture, write;
    logic                 rd_en_q, start_q, wr_en_q;
    logic [DATA_SIZE-1:0] cur_real, cur_imag, prev_real, prev_imag;
    logic [DATA_SIZE-1:0] result_q, out_din_q;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start     = 1'b0;
        capture   = 1'b0;
        write     = 1'b0;
        case (state)
            IDLE: begin
                // Both FIFOs must hold a sample; pairs are never split.
                if (!real_empty && !imag_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    capture   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!out_full) begin
                    write     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_en_q   <= 1'b0;
            start_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            cur_real  <= '0;
            cur_imag  <= '0;
            prev_real <= '0;
            prev_imag <= '0;
            result_q  <= '0;
            out_din_q <= '0;
        end else begin
            state   <= state_nxt;
            rd_en_q <= pop;
            start_q <= start;
            wr_en_q <= write;
            // FWFT heads are valid in the decision cycle, so latch them there.
            if (pop) begin
                cur_real <= real_dout;
                cur_imag <= imag_dout;
            end
            if (capture)
                result_q <= core_result;
            if (write) begin
                out_din_q <= result_q;
                prev_real <= cur_real;
                prev_imag <= cur_imag;
            end
        end
    end

    assign real_rd_en     = rd_en_q;
    assign imag_rd_en     = rd_en_q;
    assign core_start     = start_q;
    assign core_cur_real  = cur_real;
    assign core_cur_imag  = cur_imag;
    assign core_prev_real = prev_real;
    assign core_prev_imag = prev_imag;
    assign out_din        = out_din_q;
    assign out_wr_en      = wr_en_q;

`ifdef DEMOD_CTRL_COUNT_EN
    logic [31:0] count_q;

    // Counts with the write decision so the value moves together with the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else if (write)
            count_q <= count_q + 32'd1;
    end

    assign sample_count = count_q;
`else
    assign sample_count = '0;
`endif

endmodule

// File: tb/tb_demod_ctrl.sv
// Scoreboard bench for demod_ctrl: FIFO and core models, operand and output queues.
module tb_demod_ctrl;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] real_dout = '0, imag_dout = '0;
    logic          real_empty = 1'b1, imag_empty = 1'b1;
    logic          real_rd_en, imag_rd_en, core_start;
    logic [DW-1:0] core_cur_real, core_cur_imag, core_prev_real, core_prev_imag;
    logic          core_done = 1'b0;
    logic [DW-1:0] core_result = '0;
    logic [DW-1:0] out_din;
    logic          out_wr_en;
    logic          out_full = 1'b0;
    logic [31:0]   sample_count;

    always #5 clk = ~clk;

    demod_ctrl #(.DATA_SIZE(DW)) dut (
        .clk(clk), .reset(reset),
        .real_dout(real_dout), .real_empty(real_empty), .real_rd_en(real_rd_en),
        .imag_dout(imag_dout), .imag_empty(imag_empty), .imag_rd_en(imag_rd_en),
        .core_start(core_start),
        .core_cur_real(core_cur_real), .core_cur_imag(core_cur_imag),
        .core_prev_real(core_prev_real), .core_prev_imag(core_prev_imag),
        .core_done(core_done), .core_result(core_result),
        .out_din(out_din), .out_wr_en(out_wr_en), .out_full(out_full),
        .sample_count(sample_count)
    );

    typedef struct packed {
        logic [DW-1:0] cr, ci, pr, pi;
    } ops_t;

    logic [DW-1:0] rq[$], iq[$], core_q[$], exp_q[$];
    ops_t          op_q[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, pops = 0, starts = 0, writes = 0, wr_since_rst = 0;
    int rd_cyc = -100, last_lat = 0, core_lat = 2, core_cnt = 0;
    logic [DW-1:0] core_res = '0, bprev_r = '0, bprev_i = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_pair(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic [DW-1:0] res);
        rq.push_back(r);
        iq.push_back(i);
        op_q.push_back('{cr: r, ci: i, pr: bprev_r, pi: bprev_i});
        core_q.push_back(res);
        exp_q.push_back(res);
        bprev_r = r;
        bprev_i = i;
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int n = 0;
        while (writes < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, writes, target);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({tag, "_rd_en"}, {30'd0, real_rd_en, imag_rd_en}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, core_start, out_wr_en}, 32'd0);
        chk({tag, "_out_din"}, out_din, 32'd0);
        chk({tag, "_ops"}, core_cur_real | core_cur_imag | core_prev_real | core_prev_imag, 32'd0);
        chk({tag, "_count"}, sample_count, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        bprev_r = '0;
        bprev_i = '0;
        wr_since_rst = 0;
    endtask

    always @(posedge clk) cyc++;

    // FIFO, core model and monitors share one process so queue updates stay ordered.
    always @(negedge clk) begin
        ops_t e;
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done   = 1'b1;
                core_result = core_res;
            end
        end
        if (core_start) begin
            starts++;
            chk("start_expected", {31'd0, op_q.size() != 0}, 32'd1);
            if (op_q.size() != 0) begin
                e = op_q.pop_front();
                chk("cur_real", core_cur_real, e.cr);
                chk("cur_imag", core_cur_imag, e.ci);
                chk("prev_real", core_prev_real, e.pr);
                chk("prev_imag", core_prev_imag, e.pi);
            end
            core_res = (core_q.size() != 0) ? core_q.pop_front() : '0;
            core_cnt = core_lat;
        end
        if (real_rd_en || imag_rd_en) begin
            chk("rd_pair", {31'd0, imag_rd_en}, {31'd0, real_rd_en});
            if (pops > 0) chk("pop_gap", {31'd0, (cyc - rd_cyc) >= 4}, 32'd1);
            pops++;
            rd_cyc = cyc;
            if (real_rd_en && rq.size() != 0) void'(rq.pop_front());
            if (imag_rd_en && iq.size() != 0) void'(iq.pop_front());
        end
        real_empty = (rq.size() == 0);
        imag_empty = (iq.size() == 0);
        real_dout  = (rq.size() != 0) ? rq[0] : '0;
        imag_dout  = (iq.size() != 0) ? iq[0] : '0;
        if (out_wr_en) begin
            writes++;
            wr_since_rst++;
            last_lat = cyc - rd_cyc;
            chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("out_din", out_din, exp_q.pop_front());
        end
    end

    initial begin
        int snap_w, snap_p, push_cyc, n;
        logic [31:0] exp_cnt;

        #2 reset = 1'b0;
        #1;
        chk("rst_rd_en", {30'd0, real_rd_en, imag_rd_en}, 32'd0);
        chk("rst_strobes", {30'd0, core_start, out_wr_en}, 32'd0);
        chk("rst_out_din", out_din, 32'd0);
        chk("rst_count", sample_count, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // first pair: prev must be zero, fixed 5-cycle latency with a 2-cycle core
        @(posedge clk); #1;
        push_pair(32'h100, 32'h200, 32'h12345678);
        wait_writes(1, 40, "t1_write");
        chk("t1_latency", last_lat, 32'd5);
        chk("t1_pops", pops, 32'd1);

        // second pair sees the first as prev
        @(posedge clk); #1;
        push_pair(32'h300, 32'h400, 32'hCAFEF00D);
        wait_writes(2, 40, "t2_write");

        // imag empty holds off the pop
        @(posedge clk); #1;
        rq.push_back(32'h111);
        snap_p = pops;
        repeat (10) @(posedge clk);
        chk("t3_no_pop", pops, snap_p);
        #1;
        iq.push_back(32'h222);
        op_q.push_back('{cr: 32'h111, ci: 32'h222, pr: bprev_r, pi: bprev_i});
        core_q.push_back(32'h0BADBEEF);
        exp_q.push_back(32'h0BADBEEF);
        bprev_r = 32'h111;
        bprev_i = 32'h222;
        push_cyc = cyc;
        wait_writes(3, 40, "t3_write");
        chk("t3_pop_cycle", rd_cyc - push_cyc, 32'd1);

        // output back-pressure
        @(posedge clk); #1;
        out_full = 1'b1;
        push_pair(32'hA1, 32'hA2, 32'h5555AAAA);
        push_pair(32'hB1, 32'hB2, 32'hAAAA5555);
        repeat (15) @(posedge clk);
        snap_w = writes;
        repeat (7) @(posedge clk);
        chk("t4_no_write", writes, snap_w);
        chk("t4_no_pop", pops, 32'd4);
        #1 out_full = 1'b0;
        repeat (2) @(posedge clk);
        chk("t4_one_write", writes, snap_w + 1);
        wait_writes(5, 40, "t4_write2");
        chk("t4_pops", pops, 32'd5);

        // reset during WAIT discards the transaction and the late core_done
        core_lat = 20;
        @(posedge clk); #1;
        push_pair(32'h500, 32'h600, 32'hDEAD0001);
        n = 0;
        while (starts < 6 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("t5_started", starts, 32'd6);
        repeat (3) @(posedge clk);
        do_reset("t5_rst");
        repeat (30) @(posedge clk);
        chk("t5_discard", writes, 32'd5);
        core_lat = 2;
        @(posedge clk); #1;
        push_pair(32'h700, 32'h800, 32'h13579BDF);
        wait_writes(6, 40, "t5_write");

        // 50 back-to-back pairs from a fresh reset
        do_reset("t6_rst");
        core_lat = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 50; k++)
            push_pair($urandom, $urandom, $urandom);
        wait_writes(56, 1500, "t6_writes");
`ifdef DEMOD_CTRL_COUNT_EN
        exp_cnt = 32'd50;
`else
        exp_cnt = 32'd0;
`endif
        chk("t6_count", sample_count, exp_cnt);
        chk("t6_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
